// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
// Owns the PC and issues one fetch at a time to instruction memory. It then
// holds the returned instruction until the decoder acknowledges it, and
// resolves the next PC as sequential, B, BR or HLT.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   imem_req/imem_addr          single-cycle fetch request and its byte address
//   imem_valid/imem_data        memory response strobe and instruction word
//   instruction/instr_valid     held instruction and its valid flag
//   pc_out/pc_plus2             address of held instruction and that address + 2
//   instr_ack                   decoder consumes the held instruction
//   br_en/br_cond/br_offset     conditional PC-relative branch (B)
//   br_reg_en/br_reg_target     register branch (BR)
//   halt_in                     HLT instruction acknowledged
//   flag_z/flag_v/flag_n        condition flags
//   halted                      fetching has stopped until reset
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_data,
  output logic [15:0] instruction,
  output logic        instr_valid,
  output logic [15:0] pc_out,
  output logic [15:0] pc_plus2,
  input  logic        instr_ack,
  input  logic        br_en,
  input  logic [2:0]  br_cond,
  input  logic [8:0]  br_offset,
  input  logic        br_reg_en,
  input  logic [15:0] br_reg_target,
  input  logic        halt_in,
  input  logic        flag_z,
  input  logic        flag_v,
  input  logic        flag_n,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_HALTED
  } state_e;

  state_e      state_q;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, pc_out_q, pc_plus2_q;
  logic        instr_valid_q, halted_q;
  logic        cond_met;
  logic [15:0] br_target;

  always_comb begin
    cond_met = 1'b0;
    case (br_cond)
      3'b000:  cond_met = ~flag_z;
      3'b001:  cond_met = flag_z;
      3'b010:  cond_met = ~flag_z & ~flag_n;
      3'b011:  cond_met = flag_n;
      3'b100:  cond_met = flag_z | (~flag_z & ~flag_n);
      3'b101:  cond_met = flag_n | flag_z;
      3'b110:  cond_met = flag_v;
      default: cond_met = 1'b1;
    endcase
  end

  // Word offset sign-extended and scaled to bytes in one concatenation.
  assign br_target = pc_plus2_q + {{6{br_offset[8]}}, br_offset, 1'b0};

  always_comb begin
    pc_d = pc_plus2_q;
    if (halt_in)                  pc_d = pc_q;
    else if (br_reg_en)           pc_d = br_reg_target;
    else if (br_en && cond_met)   pc_d = br_target;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      pc_out_q      <= RESET_PC;
      pc_plus2_q    <= RESET_PC + 16'd2;
    end else begin
      case (state_q)
        S_FETCH: state_q <= S_WAIT;
        S_WAIT: begin
          if (imem_valid) begin
            instr_q       <= imem_data;
            pc_out_q      <= pc_q;
            pc_plus2_q    <= pc_q + 16'd2;
            instr_valid_q <= 1'b1;
            state_q       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (instr_ack) begin
            instr_valid_q <= 1'b0;
            pc_q          <= pc_d;
            if (halt_in) begin
              halted_q <= 1'b1;
              state_q  <= S_HALTED;
            end else begin
              state_q  <= S_FETCH;
            end
          end
        end
        default: state_q <= S_HALTED;
      endcase
    end
  end

  // Request is decoded from state; gating with rst keeps it low while reset is held.
  assign imem_req    = (state_q == S_FETCH) & ~rst;
  assign imem_addr   = pc_q;
  assign instruction = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc_out      = pc_out_q;
  assign pc_plus2    = pc_plus2_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [15:0] imem_data = '0;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [15:0] pc_out;
  logic [15:0] pc_plus2;
  logic        instr_ack = 1'b0;
  logic        br_en = 1'b0;
  logic [2:0]  br_cond = '0;
  logic [8:0]  br_offset = '0;
  logic        br_reg_en = 1'b0;
  logic [15:0] br_reg_target = '0;
  logic        halt_in = 1'b0;
  logic        flag_z = 1'b0;
  logic        flag_v = 1'b0;
  logic        flag_n = 1'b0;
  logic        halted;

  int pass_cnt = 0;
  int total = 0;
  int cyc = 0;

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data),
    .instruction(instruction), .instr_valid(instr_valid),
    .pc_out(pc_out), .pc_plus2(pc_plus2),
    .instr_ack(instr_ack),
    .br_en(br_en), .br_cond(br_cond), .br_offset(br_offset),
    .br_reg_en(br_reg_en), .br_reg_target(br_reg_target),
    .halt_in(halt_in),
    .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n),
    .halted(halted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a cycle with imem_req high; leaves time inside that cycle.
  task automatic wait_req(output logic ok, output logic [15:0] addr);
    ok = 1'b0;
    addr = '0;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (imem_req === 1'b1) begin
        ok = 1'b1;
        addr = imem_addr;
        break;
      end
      step();
    end
  endtask

  // From a request cycle: respond with 1-cycle latency; returns in the first HOLD cycle.
  task automatic deliver(input logic [15:0] data);
    step();
    imem_valid = 1'b1;
    imem_data  = data;
    step();
    imem_valid = 1'b0;
    imem_data  = '0;
  endtask

  task automatic fetch(input logic [15:0] data, output logic ok, output logic [15:0] addr);
    wait_req(ok, addr);
    if (ok) deliver(data);
  endtask

  // Acknowledge the held instruction with the given resolution inputs for one edge.
  task automatic ack_with(input logic b, input logic [2:0] c, input logic [8:0] o,
                          input logic r, input logic [15:0] t, input logic h,
                          input logic z, input logic v, input logic n);
    br_en = b; br_cond = c; br_offset = o; br_reg_en = r; br_reg_target = t;
    halt_in = h; flag_z = z; flag_v = v; flag_n = n;
    instr_ack = 1'b1;
    step();
    instr_ack = 1'b0;
    br_en = 1'b0; br_cond = '0; br_offset = '0; br_reg_en = 1'b0; br_reg_target = '0;
    halt_in = 1'b0; flag_z = 1'b0; flag_v = 1'b0; flag_n = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    total++; if (imem_req !== 1'b0) $display("FAIL reset_req got %b want 0", imem_req); else pass_cnt++;
    total++; if (instr_valid !== 1'b0) $display("FAIL reset_ivalid got %b want 0", instr_valid); else pass_cnt++;
    total++; if (halted !== 1'b0) $display("FAIL reset_halted got %b want 0", halted); else pass_cnt++;
    total++; if (instruction !== 16'h0000) $display("FAIL reset_instr got %h want 0000", instruction); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    logic [15:0] data [3];
    logic ok;
    logic [15:0] addr;
    int last_cyc;
    data[0] = 16'h0123; data[1] = 16'h1456; data[2] = 16'h2789;
    last_cyc = 0;
    instr_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch(data[i], ok, addr);
      total++; if (!ok || addr !== 16'(2 * i)) $display("FAIL seq_addr%0d got %h ok %b want %h", i, addr, ok, 16'(2 * i)); else pass_cnt++;
      total++; if (instr_valid !== 1'b1 || instruction !== data[i]) $display("FAIL seq_instr%0d got %b/%h want 1/%h", i, instr_valid, instruction, data[i]); else pass_cnt++;
      total++; if (pc_plus2 !== 16'(2 * i + 2) || pc_out !== 16'(2 * i)) $display("FAIL seq_pc%0d got %h/%h want %h/%h", i, pc_out, pc_plus2, 16'(2 * i), 16'(2 * i + 2)); else pass_cnt++;
      if (i > 0) begin
        total++; if (cyc - last_cyc != 3) $display("FAIL seq_spacing%0d got %0d want 3", i, cyc - last_cyc); else pass_cnt++;
      end
      last_cyc = cyc;
    end
    instr_ack = 1'b0;  // third instruction stays held
  endtask

  task automatic test_branch();
    logic [2:0]  c_t [10] = '{3'b001, 3'b001, 3'b111, 3'b000, 3'b000, 3'b010, 3'b010, 3'b011, 3'b100, 3'b110};
    logic [8:0]  o_t [10] = '{9'h1FC, 9'h1FC, 9'h0FF, 9'h1FC, 9'h1FC, 9'h1FC, 9'h1FC, 9'h1FC, 9'h1FC, 9'h1FC};
    logic        z_t [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        n_t [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        v_t [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] e_t [10] = '{16'h000A, 16'h0012, 16'h0210, 16'h000A, 16'h0012,
                              16'h000A, 16'h0012, 16'h000A, 16'h0012, 16'h000A};
    logic ok;
    logic [15:0] addr;
    for (int i = 0; i < 10; i++) begin
      ack_with(1'b0, 3'b000, 9'h000, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0);
      fetch(16'hC000, ok, addr);
      if (i == 0) begin
        total++; if (!ok || addr !== 16'h0010) $display("FAIL br_setup got %h ok %b want 0010", addr, ok); else pass_cnt++;
      end
      ack_with(1'b1, c_t[i], o_t[i], 1'b0, 16'h0000, 1'b0, z_t[i], v_t[i], n_t[i]);
      fetch(16'hC001, ok, addr);
      total++; if (!ok || addr !== e_t[i]) $display("FAIL branch%0d got %h ok %b want %h", i, addr, ok, e_t[i]); else pass_cnt++;
    end
  endtask

  task automatic test_br_priority();
    logic ok;
    logic [15:0] addr;
    ack_with(1'b1, 3'b111, 9'h1FC, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
    fetch(16'hD000, ok, addr);
    total++; if (!ok || addr !== 16'hBEEF) $display("FAIL br_prio got %h ok %b want beef", addr, ok); else pass_cnt++;
  endtask

  task automatic test_stall();
    logic ok;
    logic [15:0] addr;
    int extra_req;
    ack_with(1'b0, 3'b000, 9'h000, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_req(ok, addr);
    total++; if (!ok || addr !== 16'h0100) $display("FAIL stall_addr got %h ok %b want 0100", addr, ok); else pass_cnt++;
    extra_req = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (imem_req !== 1'b0) extra_req++;
    end
    total++; if (extra_req != 0) $display("FAIL stall_rereq got %0d want 0", extra_req); else pass_cnt++;
    imem_valid = 1'b1; imem_data = 16'hA5A5;
    step();
    imem_valid = 1'b0; imem_data = '0;
    total++; if (instr_valid !== 1'b1 || instruction !== 16'hA5A5) $display("FAIL stall_instr got %b/%h want 1/a5a5", instr_valid, instruction); else pass_cnt++;
    // Decoder stalls 4 cycles while memory strobes a stray response.
    for (int i = 0; i < 4; i++) begin
      imem_valid = 1'b1; imem_data = 16'hFFFF;
      step();
      total++; if (instruction !== 16'hA5A5 || pc_out !== 16'h0100 || instr_valid !== 1'b1 || imem_req !== 1'b0)
        $display("FAIL hold%0d got %h/%h/%b/%b want a5a5/0100/1/0", i, instruction, pc_out, instr_valid, imem_req);
      else pass_cnt++;
    end
    imem_valid = 1'b0; imem_data = '0;
  endtask

  task automatic test_halt();
    logic ok;
    logic [15:0] addr;
    int req_seen;
    ack_with(1'b0, 3'b000, 9'h000, 1'b1, 16'h0020, 1'b0, 1'b0, 1'b0, 1'b0);
    fetch(16'hF000, ok, addr);
    total++; if (!ok || addr !== 16'h0020) $display("FAIL halt_setup got %h ok %b want 0020", addr, ok); else pass_cnt++;
    // halt must outrank a simultaneous BR
    ack_with(1'b0, 3'b000, 9'h000, 1'b1, 16'h4444, 1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (halted !== 1'b1 || instr_valid !== 1'b0) $display("FAIL halt_flags got %b/%b want 1/0", halted, instr_valid); else pass_cnt++;
    total++; if (pc_out !== 16'h0020) $display("FAIL halt_pcout got %h want 0020", pc_out); else pass_cnt++;
    req_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req !== 1'b0 || halted !== 1'b1) req_seen++;
      step();
    end
    total++; if (req_seen != 0) $display("FAIL halt_quiet got %0d want 0", req_seen); else pass_cnt++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (halted !== 1'b0) $display("FAIL halt_reset got %b want 0", halted); else pass_cnt++;
    fetch(16'h0001, ok, addr);
    total++; if (!ok || addr !== 16'h0000) $display("FAIL halt_refetch got %h ok %b want 0000", addr, ok); else pass_cnt++;
  endtask

  task automatic test_wrap_and_midreset();
    logic ok;
    logic [15:0] addr;
    ack_with(1'b0, 3'b000, 9'h000, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    fetch(16'h0002, ok, addr);
    total++; if (!ok || addr !== 16'hFFFE || pc_plus2 !== 16'h0000) $display("FAIL wrap_pc got %h/%h ok %b want fffe/0000", addr, pc_plus2, ok); else pass_cnt++;
    ack_with(1'b0, 3'b000, 9'h000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_req(ok, addr);
    total++; if (!ok || addr !== 16'h0000) $display("FAIL wrap_addr got %h ok %b want 0000", addr, ok); else pass_cnt++;
    // Reset while the fetch is outstanding; no response ever arrives.
    ack_with(1'b0, 3'b000, 9'h000, 1'b1, 16'h0040, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_req(ok, addr);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (instr_valid !== 1'b0) $display("FAIL midrst_ivalid got %b want 0", instr_valid); else pass_cnt++;
    wait_req(ok, addr);
    total++; if (!ok || addr !== 16'h0000 || instr_valid !== 1'b0) $display("FAIL midrst_refetch got %h/%b ok %b want 0000/0", addr, instr_valid, ok); else pass_cnt++;
    if (ok) deliver(16'h7777);
    total++; if (instr_valid !== 1'b1 || instruction !== 16'h7777 || pc_out !== 16'h0000) $display("FAIL midrst_instr got %b/%h/%h want 1/7777/0000", instr_valid, instruction, pc_out); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_br_priority();
    test_stall();
    test_halt();
    test_wrap_and_midreset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
